// File: rtl/vmem_rect_fill.sv
// Rectangle-fill engine: CPU-programmed corners/colour, one pixel per cycle into the frame-buffer write port.
// Optional build macro VFILL_CLIP_EN clamps the far corner to SCREEN_MAX and rejects off-screen origins.
module vmem_rect_fill #(
  parameter int unsigned SCREEN_MAX = 239
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  input  logic        cpu_vmem_we_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o
);

`ifdef VFILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  localparam logic [7:0] CLIP_MAX = 8'(SCREEN_MAX);

  localparam logic [3:0] ADDR_CTRL  = 4'h0;
  localparam logic [3:0] ADDR_P0    = 4'h4;
  localparam logic [3:0] ADDR_P1    = 4'h8;
  localparam logic [3:0] ADDR_COLOR = 4'hC;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;

  logic [15:0] p0_q, p1_q;
  logic [2:0]  color_q;
  logic [7:0]  cur_x_q, cur_y_q;
  logic [7:0]  lim_x_q, lim_y_q;
  logic        done_q, err_q;

  logic        ctrl_wr, start_req, abort_req, clear_req;
  logic [7:0]  x0, y0, x1, y1;
  logic [7:0]  lim_x_c, lim_y_c;
  logic        range_ok, last_px, stall;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, reg_wdata_i[31:16]};

  // Control decode; abort in the same write suppresses start.
  assign ctrl_wr   = reg_we_i && (reg_addr_i == ADDR_CTRL);
  assign start_req = ctrl_wr && reg_wdata_i[0] && !reg_wdata_i[1];
  assign abort_req = ctrl_wr && reg_wdata_i[1];
  assign clear_req = ctrl_wr && reg_wdata_i[2];

  assign x0 = p0_q[7:0];
  assign y0 = p0_q[15:8];
  assign x1 = p1_q[7:0];
  assign y1 = p1_q[15:8];

  assign lim_x_c  = (CLIP_EN && (x1 > CLIP_MAX)) ? CLIP_MAX : x1;
  assign lim_y_c  = (CLIP_EN && (y1 > CLIP_MAX)) ? CLIP_MAX : y1;
  assign range_ok = (x0 <= lim_x_c) && (y0 <= lim_y_c) &&
                    !(CLIP_EN && ((x0 > CLIP_MAX) || (y0 > CLIP_MAX)));
  assign last_px  = (cur_x_q == lim_x_q) && (cur_y_q == lim_y_q);
  assign stall    = cpu_vmem_we_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_req && range_ok) state_d = FILL;
      FILL: begin
        if (abort_req)             state_d = IDLE;
        else if (!stall && last_px) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; the write strobe drops in the very cycle reset is sampled.
  always_comb begin
    vmem_we_o    = 1'b0;
    busy_o       = 1'b0;
    vmem_addr_o  = {cur_y_q, cur_x_q};
    vmem_wdata_o = color_q;
    if (state_q == FILL) begin
      busy_o    = 1'b1;
      vmem_we_o = !stall && !rst_i;
    end
  end

  // Registers, cursor and status; later assignments give set-over-clear priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p0_q        <= 16'h0;
      p1_q        <= 16'h0;
      color_q     <= 3'h0;
      cur_x_q     <= 8'h0;
      cur_y_q     <= 8'h0;
      lim_x_q     <= 8'h0;
      lim_y_q     <= 8'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      reg_rdata_o <= 32'h0;
    end else begin
      if (reg_we_i && (state_q != FILL)) begin
        if (reg_addr_i == ADDR_P0)    p0_q    <= reg_wdata_i[15:0];
        if (reg_addr_i == ADDR_P1)    p1_q    <= reg_wdata_i[15:0];
        if (reg_addr_i == ADDR_COLOR) color_q <= reg_wdata_i[2:0];
      end

      if (clear_req) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end

      if ((state_q == IDLE) && start_req) begin
        if (range_ok) begin
          cur_x_q <= x0;
          cur_y_q <= y0;
          lim_x_q <= lim_x_c;
          lim_y_q <= lim_y_c;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end else begin
          err_q   <= 1'b1;
        end
      end

      if ((state_q == FILL) && !abort_req && !stall) begin
        if (cur_x_q != lim_x_q) begin
          cur_x_q <= cur_x_q + 8'd1;
        end else if (cur_y_q != lim_y_q) begin
          cur_x_q <= x0;
          cur_y_q <= cur_y_q + 8'd1;
        end else begin
          done_q  <= 1'b1;
        end
      end

      case (reg_addr_i)
        ADDR_CTRL:  reg_rdata_o <= {29'h0, err_q, done_q, (state_q == FILL)};
        ADDR_P0:    reg_rdata_o <= {16'h0, p0_q};
        ADDR_P1:    reg_rdata_o <= {16'h0, p1_q};
        ADDR_COLOR: reg_rdata_o <= {29'h0, color_q};
        default:    reg_rdata_o <= 32'h0;
      endcase
    end
  end

endmodule
